spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
Command sequencer between the 10-bit SPI slave word interface and a single-port synchronous RAM. It decodes each received word by its 2-bit header into one of four actions: set write address, write data, set read address, or read data. It drives RAM write/read strobes, waits the RAM read latency, and returns read data to the slave on the tx_data/tx_valid handshake. It owns the address registers, optional auto-increment, and error flagging.

Parameters:
ADDR_WIDTH, 8, RAM address width, 1..8; payload bits [ADDR_WIDTH-1:0] are used.
MEM_RD_LATENCY, 1, cycles from o_mem_re sampled to i_mem_rdata valid, 1..3.
AUTO_INC, 1, 1 = post-increment the write address after each write and the read address after each read; 0 = hold.

Ports:
i_spi_slave_clk  in  1  clock
i_spi_slave_rst_n  in  1  reset
i_ctrl_rx_data  in  10  slave word: [9:8] command, [7:0] payload
i_ctrl_rx_valid  in  1  slave word valid; may be held high for several cycles
i_ctrl_sready  in  1  slave idle (SS deasserted, transaction finished)
o_ctrl_tx_data  out  8  read data to slave
o_ctrl_tx_valid  out  1  tx_data valid, held until released
o_mem_addr  out  ADDR_WIDTH  RAM address
o_mem_wdata  out  8  RAM write data
o_mem_we  out  1  RAM write strobe, 1-cycle pulse
o_mem_re  out  1  RAM read strobe, 1-cycle pulse
i_mem_rdata  in  8  RAM read data
o_ctrl_busy  out  1  high in any state except IDLE
o_ctrl_err  out  1  sticky error flag
i_ctrl_err_clr  in  1  synchronous clear of o_ctrl_err

Behaviour:
- Reset: i_spi_slave_rst_n is asynchronous and active-low; the clock is i_spi_slave_clk. All outputs go to 0. wr_addr, rd_addr, rd_addr_set, the latency counter and the rx_valid history register are cleared. FSM goes to IDLE. A reset during any state aborts that state; no strobe is issued afterwards.
- Command acceptance: a command is accepted only on a rising edge of i_ctrl_rx_valid (valid high in cycle N, low in N-1). Holding valid high never re-triggers.
- Command decode, in the cycle after acceptance (N+1):
  - 2'b00: wr_addr <= payload. No strobe.
  - 2'b01: o_mem_we = 1, o_mem_addr = wr_addr, o_mem_wdata = payload for exactly 1 cycle. If AUTO_INC, wr_addr increments modulo 2^ADDR_WIDTH on the same edge.
  - 2'b10: rd_addr <= payload; rd_addr_set <= 1. Clears o_ctrl_tx_valid.
  - 2'b11: if rd_addr_set, o_mem_re = 1 and o_mem_addr = rd_addr for 1 cycle, then go to RD_WAIT. If not rd_addr_set, set o_ctrl_err and return tx_data = 8'h00 with tx_valid in N+2, so the master never stalls.
- o_mem_addr is 0 when no strobe is active.
- FSM states:
  - IDLE: on an accepted command, go to WR for 01, RD_WAIT for 11 (with rd_addr_set), or stay in IDLE for 00/10 (register update only).
  - WR: lasts 1 cycle, then IDLE.
  - RD_WAIT: counts MEM_RD_LATENCY cycles after the re cycle. On the final count, capture i_mem_rdata into o_ctrl_tx_data, set o_ctrl_tx_valid, and go to RD_HOLD. tx_valid first goes high in cycle N+2+MEM_RD_LATENCY. If AUTO_INC, rd_addr increments on the capture edge.
  - RD_HOLD: tx_data/tx_valid stay stable. On i_ctrl_sready = 1, clear tx_valid and go to IDLE. An accepted command in RD_HOLD clears tx_valid and is decoded as if from IDLE.
- Rising rx_valid edge in WR or RD_WAIT: the command is dropped, o_ctrl_err is set, and the current operation completes normally.
- i_ctrl_err_clr and a new error event in the same cycle: the error wins, so err stays 1.
- i_ctrl_sready is ignored outside RD_HOLD. If sready and a command edge coincide in RD_HOLD, the command wins.
- rd_addr_set is cleared only by reset.
- Address wrap: with ADDR_WIDTH = 8, 8'hFF + 1 = 8'h00. No error is raised on wrap.

Decomposition:
- Package spi_ctrl_pkg holds:
  - Command codes: CMD_WR_ADDR = 2'b00, CMD_WR_DATA = 2'b01, CMD_RD_ADDR = 2'b10, CMD_RD_DATA = 2'b11.
  - One-hot FSM state constants: IDLE, WR, RD_WAIT, RD_HOLD.
- The rx_valid edge detector and the latency counter stay inline; no sub-module is needed.

Test Plan:
- 00 0x10, then 01 0xA5 -> o_mem_we pulses 1 cycle with addr 0x10 and wdata 0xA5; wr_addr becomes 0x11 (AUTO_INC = 1).
- Preload RAM[0x20] = 0x3C; send 10 0x20, then 11 -> o_mem_re with addr 0x20; tx_data = 0x3C, tx_valid high at N+2+L for L = 1 and L = 3; released on sready.
- 11 issued after reset, before any 10 -> o_ctrl_err = 1, tx_data = 0x00 with tx_valid; i_ctrl_err_clr then drops err.
- rx_valid held high 5 cycles with 01 0x77 -> exactly one o_mem_we pulse.
- Write address set to 0xFF, two 01 writes -> writes land at 0xFF, then 0x00.
- Reset asserted in RD_WAIT -> no tx_valid, all outputs 0; the next 11 flags err, because rd_addr_set was cleared.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared command codes and FSM state encoding for the SPI-to-RAM command sequencer.
package spi_ctrl_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    WR      = 4'b0010,
    RD_WAIT = 4'b0100,
    RD_HOLD = 4'b1000
  } state_t;

endpackage

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI slave words into RAM address/write/read actions and returns
// read data to the slave on a held tx_valid.
module spi_ram_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_RD_LATENCY = 1,
  parameter bit AUTO_INC       = 1'b1
) (
  input  logic                  i_spi_slave_clk,
  input  logic                  i_spi_slave_rst_n,
  input  logic [9:0]            i_ctrl_rx_data,
  input  logic                  i_ctrl_rx_valid,
  input  logic                  i_ctrl_sready,
  output logic [7:0]            o_ctrl_tx_data,
  output logic                  o_ctrl_tx_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_wdata,
  output logic                  o_mem_we,
  output logic                  o_mem_re,
  input  logic [7:0]            i_mem_rdata,
  output logic                  o_ctrl_busy,
  output logic                  o_ctrl_err,
  input  logic                  i_ctrl_err_clr
);

  localparam logic [1:0]            LAT = 2'(MEM_RD_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  state_t                r_state;
  logic                  r_rx_vld_q;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_addr_set;
  logic [1:0]            r_lat_cnt;
  logic                  r_rd_dummy;

  logic                  w_acc;
  logic                  w_decode;
  logic [1:0]            w_cmd;
  logic [ADDR_WIDTH-1:0] w_pl;
  logic                  w_drop;
  logic                  w_rd_noaddr;

  assign w_acc       = i_ctrl_rx_valid & ~r_rx_vld_q;
  assign w_cmd       = i_ctrl_rx_data[9:8];
  assign w_pl        = i_ctrl_rx_data[ADDR_WIDTH-1:0];
  assign w_decode    = (r_state == IDLE) || (r_state == RD_HOLD);
  assign w_drop      = w_acc & ~w_decode;
  assign w_rd_noaddr = w_acc & w_decode & (w_cmd == CMD_RD_DATA) & ~r_rd_addr_set;
  assign o_ctrl_busy = (r_state != IDLE);

  always_ff @(posedge i_spi_slave_clk or negedge i_spi_slave_rst_n) begin
    if (!i_spi_slave_rst_n) begin
      r_state         <= IDLE;
      r_rx_vld_q      <= 1'b0;
      r_wr_addr       <= '0;
      r_rd_addr       <= '0;
      r_rd_addr_set   <= 1'b0;
      r_lat_cnt       <= '0;
      r_rd_dummy      <= 1'b0;
      o_ctrl_tx_data  <= '0;
      o_ctrl_tx_valid <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_wdata     <= '0;
      o_mem_we        <= 1'b0;
      o_mem_re        <= 1'b0;
      o_ctrl_err      <= 1'b0;
    end else begin
      r_rx_vld_q <= i_ctrl_rx_valid;
      o_mem_we   <= 1'b0;
      o_mem_re   <= 1'b0;
      o_mem_addr <= '0;
      // A new error event beats a simultaneous clear.
      o_ctrl_err <= w_drop | w_rd_noaddr | (o_ctrl_err & ~i_ctrl_err_clr);

      case (r_state)
        IDLE, RD_HOLD: begin
          if (w_acc) begin
            o_ctrl_tx_valid <= 1'b0;
            r_state         <= IDLE;
            case (w_cmd)
              CMD_WR_ADDR: r_wr_addr <= w_pl;
              CMD_WR_DATA: begin
                o_mem_we    <= 1'b1;
                o_mem_addr  <= r_wr_addr;
                o_mem_wdata <= i_ctrl_rx_data[7:0];
                if (AUTO_INC) r_wr_addr <= r_wr_addr + ONE;
                r_state     <= WR;
              end
              CMD_RD_ADDR: begin
                r_rd_addr     <= w_pl;
                r_rd_addr_set <= 1'b1;
              end
              default: begin
                // Without a read address, answer 0x00 anyway so the master never stalls.
                if (r_rd_addr_set) begin
                  o_mem_re   <= 1'b1;
                  o_mem_addr <= r_rd_addr;
                end
                r_rd_dummy <= ~r_rd_addr_set;
                r_lat_cnt  <= '0;
                r_state    <= RD_WAIT;
              end
            endcase
          end else if ((r_state == RD_HOLD) && i_ctrl_sready) begin
            o_ctrl_tx_valid <= 1'b0;
            r_state         <= IDLE;
          end
        end
        WR: r_state <= IDLE;
        RD_WAIT: begin
          if (r_rd_dummy) begin
            o_ctrl_tx_data  <= 8'h00;
            o_ctrl_tx_valid <= 1'b1;
            r_state         <= RD_HOLD;
          end else if (r_lat_cnt == LAT) begin
            o_ctrl_tx_data  <= i_mem_rdata;
            o_ctrl_tx_valid <= 1'b1;
            if (AUTO_INC) r_rd_addr <= r_rd_addr + ONE;
            r_state         <= RD_HOLD;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench: a latency-1 and a latency-3 controller share stimulus, each with its own RAM model.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid, sready, err_clr;

  logic [7:0] txd1, wd1, rd1, addr1;
  logic       txv1, we1, re1, busy1, err1;
  logic [7:0] txd3, wd3, rd3, addr3;
  logic       txv3, we3, re3, busy3, err3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.ADDR_WIDTH(8), .MEM_RD_LATENCY(1), .AUTO_INC(1'b1)) u_dut1 (
    .i_spi_slave_clk(clk), .i_spi_slave_rst_n(rst_n),
    .i_ctrl_rx_data(rx_data), .i_ctrl_rx_valid(rx_valid), .i_ctrl_sready(sready),
    .o_ctrl_tx_data(txd1), .o_ctrl_tx_valid(txv1),
    .o_mem_addr(addr1), .o_mem_wdata(wd1), .o_mem_we(we1), .o_mem_re(re1),
    .i_mem_rdata(rd1), .o_ctrl_busy(busy1), .o_ctrl_err(err1), .i_ctrl_err_clr(err_clr));

  spi_ram_ctrl #(.ADDR_WIDTH(8), .MEM_RD_LATENCY(3), .AUTO_INC(1'b1)) u_dut3 (
    .i_spi_slave_clk(clk), .i_spi_slave_rst_n(rst_n),
    .i_ctrl_rx_data(rx_data), .i_ctrl_rx_valid(rx_valid), .i_ctrl_sready(sready),
    .o_ctrl_tx_data(txd3), .o_ctrl_tx_valid(txv3),
    .o_mem_addr(addr3), .o_mem_wdata(wd3), .o_mem_we(we3), .o_mem_re(re3),
    .i_mem_rdata(rd3), .o_ctrl_busy(busy3), .o_ctrl_err(err3), .i_ctrl_err_clr(err_clr));

  // RAM models: latency 1 holds the last read, latency 3 is a 3-deep pipe.
  logic [7:0] mem1 [0:255];
  logic [7:0] mem3 [0:255];
  logic [7:0] p3a, p3b;
  always @(posedge clk) begin
    if (we1) mem1[addr1] <= wd1;
    if (re1) rd1 <= mem1[addr1];
    if (we3) mem3[addr3] <= wd3;
    p3a <= re3 ? mem3[addr3] : 8'h00;
    p3b <= p3a;
    rd3 <= p3b;
  end

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] pl;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rising rx_valid edge for one cycle; returns at the first negedge after the sampling edge.
  task automatic send(input logic [1:0] cmd, input logic [7:0] pl);
    @(negedge clk);
    rx_data  = {cmd, pl};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int we_cnt;
    int txv_cnt;
    tbl[0] = '{2'b00, 8'h10, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{2'b01, 8'hA5, 1'b1, 8'h10, 8'hA5};
    tbl[2] = '{2'b01, 8'h5A, 1'b1, 8'h11, 8'h5A};
    tbl[3] = '{2'b00, 8'hFF, 1'b0, 8'h00, 8'h00};
    tbl[4] = '{2'b01, 8'h01, 1'b1, 8'hFF, 8'h01};
    tbl[5] = '{2'b01, 8'h02, 1'b1, 8'h00, 8'h02};
    tbl[6] = '{2'b00, 8'h20, 1'b0, 8'h00, 8'h00};
    tbl[7] = '{2'b01, 8'h3C, 1'b1, 8'h20, 8'h3C};

    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; sready = 1'b0; err_clr = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("reset_outs", {txd1, txv1, addr1, wd1, we1, re1, busy1, err1}, '0);

    // Read before any read address: error plus a dummy 0x00 reply
    send(2'b11, 8'h00);
    chk("noaddr_err", err1, 1'b1);
    chk("noaddr_re", re1, 1'b0);
    chk("noaddr_busy", busy1, 1'b1);
    idle(1);
    chk("noaddr_txv", {txv1, txd1}, {1'b1, 8'h00});
    sready = 1'b1; idle(1); sready = 1'b0;
    chk("noaddr_release", {txv1, busy1}, 2'b00);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("err_clr", err1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].cmd, tbl[i].pl);
      chk($sformatf("vec%0d_we", i), we1, tbl[i].we);
      chk($sformatf("vec%0d_addr", i), addr1, tbl[i].addr);
      if (tbl[i].we) chk($sformatf("vec%0d_wdata", i), wd1, tbl[i].wdata);
      chk($sformatf("vec%0d_busy", i), busy1, tbl[i].we);
      idle(1);
      chk($sformatf("vec%0d_we_off", i), we1, 1'b0);
      idle(1);
    end

    // rx_valid held 5 cycles: exactly one write strobe
    we_cnt = 0;
    @(negedge clk);
    rx_data = {2'b01, 8'h77}; rx_valid = 1'b1;
    repeat (5) begin @(negedge clk); if (we1) we_cnt++; end
    rx_valid = 1'b0;
    repeat (3) begin @(negedge clk); if (we1) we_cnt++; end
    chk("held_valid_we_count", we_cnt, 1);

    // Read of RAM[0x20] = 0x3C with both latencies
    send(2'b10, 8'h20);
    chk("rdaddr_no_re", re1, 1'b0);
    idle(2);
    send(2'b11, 8'h00);
    chk("rd_re1", {re1, addr1}, {1'b1, 8'h20});
    chk("rd_re3", {re3, addr3}, {1'b1, 8'h20});
    idle(1);
    chk("rd_k2", {re1, txv1, txv3}, 3'b000);
    idle(1);
    chk("rd_l1_txv", {txv1, txd1}, {1'b1, 8'h3C});
    chk("rd_l3_k3", txv3, 1'b0);
    idle(1);
    chk("rd_l3_k4", txv3, 1'b0);
    idle(1);
    chk("rd_l3_txv", {txv3, txd3}, {1'b1, 8'h3C});
    chk("rd_l1_hold", {txv1, txd1}, {1'b1, 8'h3C});
    sready = 1'b1; idle(1); sready = 1'b0;
    chk("rd_release", {txv1, txv3, busy1, busy3}, 4'b0000);
    chk("rd_no_err", err1, 1'b0);

    // Second read uses the incremented address
    send(2'b11, 8'h00);
    chk("rd_inc_addr", {re1, addr1}, {1'b1, 8'h21});
    idle(5);
    sready = 1'b1; idle(1); sready = 1'b0;

    // Reset while in RD_WAIT aborts the read and forgets rd_addr_set
    send(2'b10, 8'h20);
    idle(1);
    send(2'b11, 8'h00);
    chk("pre_rst_busy", busy3, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("rst_outs1", {txd1, txv1, addr1, wd1, we1, re1, busy1, err1}, '0);
    chk("rst_outs3", {txd3, txv3, addr3, wd3, we3, re3, busy3, err3}, '0);
    idle(2);
    rst_n = 1'b1;
    txv_cnt = 0;
    repeat (6) begin @(negedge clk); if (txv1 || txv3) txv_cnt++; end
    chk("rst_no_txv", txv_cnt, 0);
    send(2'b11, 8'h00);
    chk("rst_rdset_cleared", {err1, re1, err3, re3}, 4'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
